// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - elastic DEPTH-stage valid/ready pipeline register; optional flush port under REG_PIPE_FLUSH_EN
module reg_pipe #(
  parameter int                   DATAWIDTH = 8,
  parameter int                   DEPTH     = 2,
  parameter logic [DATAWIDTH-1:0] RESET_VAL = '0,
  parameter int                   CNTW      = $clog2(DEPTH + 1)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
`ifdef REG_PIPE_FLUSH_EN
  input  logic                 flush,
`endif
  output logic [CNTW-1:0]      occupancy
);

  logic [DEPTH-1:0]     v;
  logic [DEPTH-1:0]     v_nxt;
  logic [DEPTH-1:0]     adv;
  logic [DEPTH-1:0]     src_v;
  logic [DEPTH-1:0]     ld;
  logic [DATAWIDTH-1:0] d     [DEPTH];
  logic [DATAWIDTH-1:0] src_d [DEPTH];
  logic [CNTW-1:0]      occ_nxt;
  logic                 kill;

`ifdef REG_PIPE_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // Each stage is fed by the one before it; stage 0 is fed by the upstream port.
  assign src_v[0] = in_valid;
  assign src_d[0] = in_data;

  generate
    for (genvar i = 1; i < DEPTH; i++) begin : g_src
      assign src_v[i] = v[i-1];
      assign src_d[i] = d[i-1];
    end
  endgenerate

  // Advance chain, built from the output side: a stage may move if it is empty or everything below it moves.
  always_comb begin : p_adv
    logic acc;
    adv = '0;
    acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~v[i];
      adv[i] = acc;
    end
  end

  // Next valid bits, data load enables and the population count that occupancy registers.
  always_comb begin
    v_nxt   = v;
    ld      = '0;
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (adv[i]) begin
        v_nxt[i] = src_v[i];
      end
      ld[i] = adv[i] & src_v[i] & ~kill;
    end
    if (kill) begin
      v_nxt = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + CNTW'(v_nxt[i]);
    end
  end

  // Stage registers; data only loads when a valid word arrives so bubbles never overwrite held words.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else begin
      v         <= v_nxt;
      occupancy <= occ_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (ld[i]) begin
          d[i] <= src_d[i];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_reg_pipe.sv
// tb/tb_reg_pipe.sv - directed self-checking bench for reg_pipe (DEPTH=3 and DEPTH=4 instances)
module tb_reg_pipe;

  logic       clk;
  logic       a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
`ifdef REG_PIPE_FLUSH_EN
  logic       a_flush;
  logic       b_flush;
`endif
  logic       b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [2:0] b_occ;

  int tests;
  int fails;

  reg_pipe #(.DATAWIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_dut3 (
    .Clk       (clk),
    .Rst       (a_rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
`ifdef REG_PIPE_FLUSH_EN
    .flush     (a_flush),
`endif
    .occupancy (a_occ)
  );

  reg_pipe #(.DATAWIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut4 (
    .Clk       (clk),
    .Rst       (b_rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
`ifdef REG_PIPE_FLUSH_EN
    .flush     (b_flush),
`endif
    .occupancy (b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] rx [8];
    int nrx;
    int acc_n;
    int con_n;
    int nvalid;
    tests = 0;
    fails = 0;
    a_rst = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
    b_rst = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
`ifdef REG_PIPE_FLUSH_EN
    a_flush = 1'b0;
    b_flush = 1'b0;
`endif

    // reset
    tick();
    tick();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_out_data", a_out_data, 8'hA5);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_b_occ", b_occ, 0);
    a_rst = 1'b1;
    b_rst = 1'b1;

    // streaming 01..0A with out_ready held high
    a_out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      a_in_valid = (c < 10);
      a_in_data  = 8'(c + 1);
      #1;
      if (c < 10) chk("stream_in_ready", a_in_ready, 1);
      tick();
      acc_n = (c + 1 < 10) ? c + 1 : 10;
      con_n = (c < 2) ? 0 : ((c - 2 > 10) ? 10 : c - 2);
      chk("stream_occ", a_occ, acc_n - con_n);
      chk("stream_out_valid", a_out_valid, (c >= 2 && c <= 11) ? 1 : 0);
      if (c >= 2 && c <= 11) chk("stream_out_data", a_out_data, 8'(c - 1));
    end
    chk("stream_empty_in_ready", a_in_ready, 1);

    // backpressure
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data = 8'h11; tick(); chk("bp_occ1", a_occ, 1);
    a_in_data = 8'h22; tick(); chk("bp_occ2", a_occ, 2);
    a_in_data = 8'h33; tick(); chk("bp_occ3", a_occ, 3);
    a_in_data = 8'h44; #1;
    chk("bp_full_in_ready", a_in_ready, 0);
    tick();
    chk("bp_hold_occ", a_occ, 3);
    chk("bp_hold_data", a_out_data, 8'h11);
    a_out_ready = 1'b1; #1;
    chk("bp_full_drain_in_ready", a_in_ready, 1);
    nrx = 0;
    for (int k = 0; k < 6; k++) begin
      if (a_out_valid && nrx < 8) begin
        rx[nrx] = a_out_data;
        nrx++;
      end
      tick();
      if (k == 0) begin
        chk("bp_swap_occ", a_occ, 3);
        a_in_valid = 1'b0;
      end
    end
    chk("bp_rx_count", nrx, 4);
    chk("bp_rx0", rx[0], 8'h11);
    chk("bp_rx1", rx[1], 8'h22);
    chk("bp_rx2", rx[2], 8'h33);
    chk("bp_rx3", rx[3], 8'h44);
    chk("bp_end_occ", a_occ, 0);

    // mid-stream reset
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data = 8'h81; tick();
    a_in_data = 8'h82; tick();
    a_in_data = 8'h83; tick();
    chk("mrst_pre_occ", a_occ, 3);
    a_rst = 1'b0; a_in_data = 8'h99;
    tick();
    chk("mrst_occ", a_occ, 0);
    chk("mrst_out_valid", a_out_valid, 0);
    chk("mrst_out_data", a_out_data, 8'hA5);
    a_rst = 1'b1; a_out_ready = 1'b1; a_in_data = 8'hC3;
    tick();
    a_in_valid = 1'b0;
    chk("mrst_lat_e0", a_out_valid, 0);
    tick();
    chk("mrst_lat_e1", a_out_valid, 0);
    tick();
    chk("mrst_lat_e2_valid", a_out_valid, 1);
    chk("mrst_lat_e2_data", a_out_data, 8'hC3);
    tick();
    chk("mrst_lat_e3", a_out_valid, 0);
    chk("mrst_end_occ", a_occ, 0);

    // bubble collapse on the DEPTH=4 instance
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1; b_in_data = 8'h5A;
    tick();
    b_in_valid = 1'b0;
    tick(); tick(); tick();
    chk("bub_5a_valid", b_out_valid, 1);
    chk("bub_5a_data", b_out_data, 8'h5A);
    chk("bub_occ1", b_occ, 1);
    b_in_valid = 1'b1; b_in_data = 8'h5B; #1;
    chk("bub_stall_in_ready", b_in_ready, 1);
    tick();
    b_in_valid = 1'b0;
    tick(); tick();
    chk("bub_occ2", b_occ, 2);
    chk("bub_in_ready", b_in_ready, 1);
    chk("bub_hold_data", b_out_data, 8'h5A);
    tick(); tick();
    chk("bub_occ2_hold", b_occ, 2);
    b_out_ready = 1'b1;
    tick();
    chk("bub_5b_valid", b_out_valid, 1);
    chk("bub_5b_data", b_out_data, 8'h5B);
    chk("bub_occ_drain", b_occ, 1);
    tick();
    chk("bub_empty_valid", b_out_valid, 0);
    chk("bub_empty_occ", b_occ, 0);

`ifdef REG_PIPE_FLUSH_EN
    // flush
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data = 8'h61; tick();
    a_in_data = 8'h62; tick();
    chk("fl_pre_occ", a_occ, 2);
    a_in_data = 8'h77; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_occ", a_occ, 0);
    chk("fl_out_valid", a_out_valid, 0);
    a_out_ready = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (a_out_valid) nvalid++;
    end
    chk("fl_nothing_emerges", nvalid, 0);
    a_in_valid = 1'b1; a_in_data = 8'h3C;
    tick(); tick(); tick();
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    a_flush = 1'b1; a_rst = 1'b0;
    tick();
    a_flush = 1'b0; a_rst = 1'b1;
    chk("fl_rst_data", a_out_data, 8'hA5);
    chk("fl_rst_occ", a_occ, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_pipe.md
Name: reg_pipe

Overview:
- Parametrised, elastic, multi-stage pipeline register with a per-stage valid bit and a valid/ready handshake on both sides.
- Generalises the single register to DEPTH stages with backpressure, bubble collapsing, a parametrised reset value and an occupancy count.
- Used between datapath blocks to add latency and retiming without losing or duplicating words under stall.

Parameters:
- DATAWIDTH, 8, width of the data word (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every bit of every data stage on reset (DATAWIDTH bits).
- CNTW, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of Clk.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage 0 can accept a word this cycle.
- in_data  in  DATAWIDTH  upstream word.
- out_valid  out  1  last stage holds a valid word.
- out_ready  in  1  downstream accepts a word this cycle.
- out_data  out  DATAWIDTH  last-stage word.
- occupancy  out  CNTW  number of valid stages, 0..DEPTH.
- flush  in  1  present only with REG_PIPE_FLUSH_EN; see Optional Feature.

Behaviour:
- State: v[i] and d[i] for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 is the output side.
- Combinational advance chain:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1].
  - in_ready = adv[0]. There is a combinational path from out_ready to in_ready; this is intentional.
- On a rising edge with Rst=1, for each stage i where adv[i]=1:
  - v[i] <= (i==0 ? in_valid : v[i-1]).
  - d[i] <= (i==0 ? in_data : d[i-1]), but only when the incoming valid is 1; otherwise d[i] holds.
- Stages with adv[i]=0 hold both v and d.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - in_data is ignored when in_valid=0. out_data is don't-care when out_valid=0, but equals the held register in practice.
- Outputs: out_valid = v[DEPTH-1], out_data = d[DEPTH-1].
- occupancy is the registered population count of v, updated the same edge as v. It is not combinational from v.
- Latency and throughput: with out_ready held at 1, a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, and is consumed at edge N+DEPTH. Sustained throughput is 1 word/cycle.
- Bubbles: an empty stage always advances, so gaps collapse under downstream stall. A pipeline that is stalled but not full still accepts input.
- Full: all v=1 and out_ready=0 gives in_ready=0, and nothing moves. A simultaneous output and input transfer when full is legal; occupancy stays DEPTH.
- Empty: occupancy=0, out_valid=0, in_ready=1.
- Order is preserved; no word is dropped or duplicated under any out_ready pattern.
- Reset (Rst=0 at the edge, including mid-stream):
  - All v cleared, so out_valid=0 and occupancy=0.
  - Every bit of every d[i] loads RESET_VAL, including the MSB; out_data=RESET_VAL.
  - In-flight words are discarded; inputs are ignored on that edge.
  - in_ready is combinational and reads 1 during reset. Upstream must not count a transfer while Rst=0.
- DEPTH=1 reduces to a single valid/ready register with in_ready = !v[0] | out_ready.

Optional Feature:
- Macro: REG_PIPE_FLUSH_EN.
- Defined:
  - The flush port exists.
  - flush=1 at a rising edge clears all v and sets occupancy to 0. Data registers hold.
  - Any input presented that cycle is discarded, even if in_ready=1.
  - Reset has priority over flush.
- Undefined: no flush port and no flush logic; behaviour is otherwise identical.

Test Plan:
- Reset: DATAWIDTH=8, DEPTH=3, RESET_VAL=8'hA5; drive Rst=0 for 2 edges -> out_valid=0, occupancy=0, out_data=8'hA5 (all 8 bits), in_ready=1.
- Streaming: out_ready=1; send 8'h01..8'h0A back-to-back -> first out_valid rises 2 edges after the first accept; 10 outputs in order 01..0A on consecutive cycles; occupancy steady at 3 mid-stream.
- Backpressure: out_ready=0; send 8'h11, 8'h22, 8'h33, 8'h44 -> first three accepted, in_ready=0 when occupancy=3, 44 held upstream. Then out_ready=1 -> outputs 11, 22, 33, 44 with no loss or duplicate.
- Bubble collapse: DEPTH=4; send one word 8'h5A with out_ready=0, then after 3 idle cycles send 8'h5B -> 5A sits in stage 3, 5B reaches stage 2 and in_ready stays 1, occupancy=2.
- Mid-stream reset: with occupancy=3, pulse Rst=0 for one edge -> occupancy=0, out_valid=0, no pre-reset word emerges afterward. Then send 8'hC3 -> emerges after DEPTH-cycle latency.
- REG_PIPE_FLUSH_EN: with occupancy=2 and in_valid=1 (8'h77), assert flush for one edge -> occupancy=0, 8'h77 never emerges. Flush and Rst=0 together -> data registers load RESET_VAL.
